dc_fu_axi_burst_reader: RTL and testbench
=========================================

Name: dc_fu_axi_burst_reader

Overview:
- Fetch-unit read engine; the responder end of the line translator's start_fetch / fetch_word_count / line_addr / fetch_in_progress / error_flag interface.
- Accepts one line-fetch command and splits it into AXI4 INCR read bursts, one burst outstanding at a time.
- Streams the returned words to the line buffer over a valid/ready interface and reports completion and error status back to the translator.

Parameters:
- AXI_ARADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI read data width in bits; power of two, at least 8.
- FETCH_WORD_COUNT_WIDTH, 16, width of the command word count.
- MAX_BURST_LEN, 16, maximum beats per burst; range 1..256.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- en  in  1  global enable; when low, every register holds its value.
- start_fetch  in  1  single-cycle command strobe.
- fetch_word_count  in  FETCH_WORD_COUNT_WIDTH  number of AXI words to read; sampled with start_fetch.
- line_addr  in  AXI_ARADDR_WIDTH  start byte address; sampled with start_fetch.
- fetch_in_progress  out  1  high while a command is active.
- error_flag  out  2  first non-OKAY RRESP seen in the current command.
- m_araddr  out  AXI_ARADDR_WIDTH  burst start address.
- m_arlen  out  8  beats minus one.
- m_arsize  out  3  constant log2(AXI_DATA_WIDTH/8).
- m_arburst  out  2  constant INCR (2'b01).
- m_arvalid  out  1  read-address valid.
- m_arready  in  1  read-address ready.
- m_rdata  in  AXI_DATA_WIDTH  read data.
- m_rresp  in  2  read response.
- m_rlast  in  1  last beat of the burst.
- m_rvalid  in  1  read-data valid.
- m_rready  out  1  read-data ready.
- out_data  out  AXI_DATA_WIDTH  word to the line buffer.
- out_last  out  1  marks the final word of the line.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.

Behaviour:
- Reset (nrst low at a clock edge):
  - state returns to IDLE.
  - fetch_in_progress=0, error_flag=0, m_arvalid=0, m_araddr=0, m_arlen=0, m_rready=0, out_valid=0.
  - A reset mid-burst abandons the transaction; the interconnect is reset together with this block.
- FSM states: IDLE, ADDR, DATA, CHECK.
- IDLE:
  - On start_fetch with en high: latch the address with its low log2(bytes per beat) bits forced to 0, latch the count, clear error_flag, set fetch_in_progress.
  - fetch_in_progress must be high in the cycle after start_fetch; the translator samples it then.
  - If the count is nonzero, go to ADDR.
  - If the count is 0, go to CHECK, so fetch_in_progress is high for exactly one cycle and no AR is issued.
- ADDR:
  - m_arvalid is registered and m_araddr/m_arlen are registered together with it.
  - len = min(remaining, MAX_BURST_LEN, beats left to the next 4 KB boundary), where beats left = (4096 - addr[11:0]) / bytes per beat.
  - m_arlen = len - 1.
  - While ARREADY is low, m_arvalid, m_araddr and m_arlen stay stable.
  - On handshake: address += len * bytes per beat; remaining -= len; go to DATA.
- DATA:
  - m_rready = out_ready & en.
  - out_valid = m_rvalid & en, combinational pass-through.
  - out_data = m_rdata.
  - out_last = m_rlast & (remaining == 0).
  - On each beat with rresp != 0 and error_flag == 0, capture rresp into error_flag (sticky).
  - On the beat where m_rlast is accepted, go to CHECK.
- CHECK: if remaining > 0, go to ADDR; otherwise clear fetch_in_progress and go to IDLE.
- start_fetch outside IDLE is ignored.
- Overhead is one idle cycle per burst (the CHECK state).
- Arithmetic: the address wraps modulo 2^AXI_ARADDR_WIDTH. The beat counter is FETCH_WORD_COUNT_WIDTH wide; the len path is 9 bits wide so that MAX_BURST_LEN = 256 is representable.

Optional Feature:
- Macro: DC_FU_ABORT_ON_ERROR_EN.
- Defined: after any non-OKAY beat, the current burst drains normally and is forwarded, then CHECK forces remaining = 0, the command ends, and no further AR is issued.
- Undefined: all bursts are issued regardless of errors; error_flag is reported only.

Decomposition:
- Package dc_fu_pkg holds:
  - the FSM state enum;
  - AXI_BURST_INCR;
  - RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR;
  - the 4 KB page constant.
- Sub-module dc_fu_burst_len_calc: a combinational min(remaining, MAX_BURST_LEN, beats to the 4 KB boundary) unit, with its own unit test.

Test Plan:
- Single burst: addr 0x1000, count 16, 64-bit data -> one AR with araddr 0x1000 and arlen 15. Expect 16 output words with out_last on word 16; fetch_in_progress drops 2 cycles after the last beat.
- Multi-burst: addr 0x2000, count 40 -> ARs (0x2000, len 15), (0x2080, len 15), (0x2100, len 7).
- 4 KB split: addr 0x0FF0, count 8 -> ARs (0x0FF0, len 1) and (0x1000, len 5).
- Backpressure: out_ready low for 5 cycles mid-burst -> m_rready low for those cycles; all 16 words delivered in order; en low for 3 cycles freezes all state.
- Error: rresp=2 on beat 3 of burst 1 of a 40-word command -> error_flag=2 and stays 2. With the macro, no second AR is issued; without it, 3 ARs are issued.
- Zero and overlap: count 0 -> fetch_in_progress high exactly 1 cycle with no AR. A start_fetch issued during ADDR is ignored. nrst low mid-DATA -> all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/dc_fu_pkg.sv
// Shared types and constants for the fetch-unit AXI burst reader.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dc_fu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI bursts must not cross this many bytes
    localparam int unsigned PAGE_BYTES = 4096;

endpackage

// File: rtl/dc_fu_burst_len_calc.sv
// Burst length = min(remaining, MAX_BURST_LEN, beats left before the next 4 KB page).
// Latency: purely combinational.
// Backpressure: none; result is only consumed when a burst is launched.
module dc_fu_burst_len_calc
    import dc_fu_pkg::*;
#(
    parameter int REM_WIDTH     = 16,
    parameter int BYTE_SHIFT    = 3,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [REM_WIDTH-1:0] remaining,
    input  logic [11:0]          page_offset,
    output logic [8:0]           len
);

    // Common compare width wide enough for the word count and a full page of byte beats
    localparam int CW = (REM_WIDTH > 13) ? REM_WIDTH : 13;

    logic [12:0]   page_beats;
    logic [CW-1:0] cap;

    // Three-way minimum; result never exceeds MAX_BURST_LEN so it fits in 9 bits
    always_comb begin
        page_beats = (13'(PAGE_BYTES) - {1'b0, page_offset}) >> BYTE_SHIFT;
        cap        = CW'(MAX_BURST_LEN);
        if (CW'(page_beats) < cap) cap = CW'(page_beats);
        if (CW'(remaining) < cap)  cap = CW'(remaining);
        len = 9'(cap);
    end

endmodule

// File: rtl/dc_fu_axi_burst_reader.sv
// Line-fetch read engine: splits one command into 4 KB-safe AXI4 INCR bursts, one outstanding at a time.
// Latency: AR issued 1 cycle after start_fetch; R beats pass straight through; 1 CHECK cycle per burst.
// Backpressure: m_rready follows out_ready & en; en low freezes all state. DC_FU_ABORT_ON_ERROR_EN stops after an errored burst.
module dc_fu_axi_burst_reader
    import dc_fu_pkg::*;
#(
    parameter int AXI_ARADDR_WIDTH       = 32,
    parameter int AXI_DATA_WIDTH         = 64,
    parameter int FETCH_WORD_COUNT_WIDTH = 16,
    parameter int MAX_BURST_LEN          = 16
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic                              start_fetch,
    input  logic [FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
    input  logic [AXI_ARADDR_WIDTH-1:0]       line_addr,
    output logic                              fetch_in_progress,
    output logic [1:0]                        error_flag,
    output logic [AXI_ARADDR_WIDTH-1:0]       m_araddr,
    output logic [7:0]                        m_arlen,
    output logic [2:0]                        m_arsize,
    output logic [1:0]                        m_arburst,
    output logic                              m_arvalid,
    input  logic                              m_arready,
    input  logic [AXI_DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                        m_rresp,
    input  logic                              m_rlast,
    input  logic                              m_rvalid,
    output logic                              m_rready,
    output logic [AXI_DATA_WIDTH-1:0]         out_data,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT     = $clog2(BYTES_PER_BEAT);

    fetch_state_t                      state;
    logic [AXI_ARADDR_WIDTH-1:0]       addr_q;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] remaining_q;

    logic [AXI_ARADDR_WIDTH-1:0]       aligned_line_addr;
    logic [FETCH_WORD_COUNT_WIDTH-1:0] calc_rem;
    logic [11:0]                       calc_page_off;
    logic [8:0]                        calc_len;
    logic [8:0]                        burst_len;
    logic                              r_beat;
    logic                              check_more;

    assign aligned_line_addr = line_addr & ~AXI_ARADDR_WIDTH'(BYTES_PER_BEAT - 1);

    // In IDLE the first burst is sized from the incoming command, otherwise from the running state
    always_comb begin
        calc_rem      = remaining_q;
        calc_page_off = addr_q[11:0];
        if (state == ST_IDLE) begin
            calc_rem      = fetch_word_count;
            calc_page_off = aligned_line_addr[11:0];
        end
    end

    dc_fu_burst_len_calc #(
        .REM_WIDTH    (FETCH_WORD_COUNT_WIDTH),
        .BYTE_SHIFT   (BYTE_SHIFT),
        .MAX_BURST_LEN(MAX_BURST_LEN)
    ) u_len_calc (
        .remaining  (calc_rem),
        .page_offset(calc_page_off),
        .len        (calc_len)
    );

    assign burst_len = {1'b0, m_arlen} + 9'd1;

    assign m_arsize  = 3'(BYTE_SHIFT);
    assign m_arburst = AXI_BURST_INCR;
    assign m_rready  = (state == ST_DATA) & out_ready & en;
    assign out_valid = (state == ST_DATA) & m_rvalid & en;
    assign out_data  = m_rdata;
    assign out_last  = (state == ST_DATA) & m_rlast & (remaining_q == '0);
    assign r_beat    = m_rvalid & m_rready;

`ifdef DC_FU_ABORT_ON_ERROR_EN
    // An errored command ends after the burst in flight has drained
    assign check_more = (remaining_q != '0) && (error_flag == RESP_OKAY);
`else
    assign check_more = (remaining_q != '0);
`endif

    // Command FSM with registered AR channel and status outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state             <= ST_IDLE;
            addr_q            <= '0;
            remaining_q       <= '0;
            fetch_in_progress <= 1'b0;
            error_flag        <= RESP_OKAY;
            m_arvalid         <= 1'b0;
            m_araddr          <= '0;
            m_arlen           <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start_fetch) begin
                        addr_q            <= aligned_line_addr;
                        remaining_q       <= fetch_word_count;
                        error_flag        <= RESP_OKAY;
                        fetch_in_progress <= 1'b1;
                        if (fetch_word_count != '0) begin
                            state     <= ST_ADDR;
                            m_arvalid <= 1'b1;
                            m_araddr  <= aligned_line_addr;
                            m_arlen   <= 8'(calc_len - 9'd1);
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        m_arvalid   <= 1'b0;
                        addr_q      <= addr_q + (AXI_ARADDR_WIDTH'(burst_len) << BYTE_SHIFT);
                        remaining_q <= remaining_q - FETCH_WORD_COUNT_WIDTH'(burst_len);
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_beat) begin
                        if ((m_rresp != RESP_OKAY) && (error_flag == RESP_OKAY)) begin
                            error_flag <= m_rresp;
                        end
                        if (m_rlast) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (check_more) begin
                        state     <= ST_ADDR;
                        m_arvalid <= 1'b1;
                        m_araddr  <= addr_q;
                        m_arlen   <= 8'(calc_len - 9'd1);
                    end else begin
                        remaining_q       <= '0;
                        fetch_in_progress <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_fu_axi_burst_reader.sv
// Scoreboard bench for the line-fetch burst reader with a small AXI read responder.
// Latency: expected AR/word traffic is queued at issue time and popped as the DUT presents it.
// Backpressure: responder can stall ARREADY; bench toggles out_ready and en.
module tb_dc_fu_axi_burst_reader;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int FW  = 16;
    localparam int MBL = 16;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          start_fetch;
    logic [FW-1:0] fetch_word_count;
    logic [AW-1:0] line_addr;
    logic          fetch_in_progress;
    logic [1:0]    error_flag;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    dc_fu_axi_burst_reader #(
        .AXI_ARADDR_WIDTH      (AW),
        .AXI_DATA_WIDTH        (DW),
        .FETCH_WORD_COUNT_WIDTH(FW),
        .MAX_BURST_LEN         (MBL)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .en               (en),
        .start_fetch      (start_fetch),
        .fetch_word_count (fetch_word_count),
        .line_addr        (line_addr),
        .fetch_in_progress(fetch_in_progress),
        .error_flag       (error_flag),
        .m_araddr         (m_araddr),
        .m_arlen          (m_arlen),
        .m_arsize         (m_arsize),
        .m_arburst        (m_arburst),
        .m_arvalid        (m_arvalid),
        .m_arready        (m_arready),
        .m_rdata          (m_rdata),
        .m_rresp          (m_rresp),
        .m_rlast          (m_rlast),
        .m_rvalid         (m_rvalid),
        .m_rready         (m_rready),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_exp_t;
    typedef struct { logic [DW-1:0] data; logic last; } w_exp_t;

    ar_exp_t exp_ar[$];
    w_exp_t  exp_w[$];
    ar_exp_t ar_e;
    w_exp_t  w_e;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ar_seen = 0;
    int words_seen = 0;
    int last_cyc = 0;

    logic          ar_pend = 1'b0;
    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_len;

    // responder controls and state
    logic          slv_rst;
    int            ar_stall;
    int            inj_burst;
    int            inj_beat;
    logic [1:0]    inj_resp;
    logic          s_busy;
    logic [AW-1:0] s_addr;
    int            s_len, s_beat, s_burst, ar_wait;
    logic          ar_hs, r_hs;
    logic [AW-1:0] cap_addr;
    logic [7:0]    cap_len;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] l);
        ar_exp_t e;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
    endtask

    task automatic push_words(input logic [AW-1:0] a, input int n, input logic final_last);
        w_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = pat(a + 32'(i) * 32'd8);
            e.last = final_last && (i == n - 1);
            exp_w.push_back(e);
        end
    endtask

    task automatic drive_beat();
        m_rvalid = 1'b1;
        m_rdata  = pat(s_addr + 32'(s_beat) * 32'd8);
        m_rresp  = (s_burst == inj_burst && s_beat == inj_beat) ? inj_resp : 2'b00;
        m_rlast  = (s_beat == s_len);
    endtask

    // AXI read responder: one burst at a time, changes its outputs 2 time units after the edge
    initial begin
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
        s_busy = 1'b0; s_addr = '0; s_len = 0; s_beat = 0; s_burst = 0; ar_wait = 0;
        forever begin
            @(negedge clk);
            ar_hs    = m_arvalid && m_arready;
            r_hs     = m_rvalid && m_rready;
            cap_addr = m_araddr;
            cap_len  = m_arlen;
            @(posedge clk);
            #2;
            if (slv_rst) begin
                s_busy = 1'b0; s_burst = 0; ar_wait = 0;
                m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
            end else begin
                if (r_hs) begin
                    if (s_beat == s_len) begin
                        s_busy = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
                    end else begin
                        s_beat++;
                        drive_beat();
                    end
                end
                if (ar_hs) begin
                    s_busy = 1'b1; s_addr = cap_addr; s_len = int'(cap_len); s_beat = 0;
                    s_burst++;
                    drive_beat();
                end
                if (!s_busy && m_arvalid) begin
                    if (ar_wait >= ar_stall) m_arready = 1'b1;
                    else begin ar_wait++; m_arready = 1'b0; end
                end else begin
                    m_arready = 1'b0;
                    ar_wait   = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every AR and output handshake, checks AR stability under stall
    initial begin
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (ar_pend) begin
                    chk("ar_hold_valid", m_arvalid, 1);
                    chk("ar_hold_addr", m_araddr, pend_addr);
                    chk("ar_hold_len", m_arlen, pend_len);
                end
                if (m_arvalid && m_arready) begin
                    ar_seen++;
                    if (exp_ar.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL ar_unexpected: got addr 0x%0h len %0d, none expected", m_araddr, m_arlen);
                    end else begin
                        ar_e = exp_ar.pop_front();
                        chk("ar_addr", m_araddr, ar_e.addr);
                        chk("ar_len", m_arlen, ar_e.len);
                    end
                end
                ar_pend   = m_arvalid && !m_arready;
                pend_addr = m_araddr;
                pend_len  = m_arlen;
                if (out_valid && out_ready) begin
                    words_seen++;
                    if (out_last) last_cyc = cyc;
                    if (exp_w.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL word_unexpected: got data 0x%0h, none expected", out_data);
                    end else begin
                        w_e = exp_w.pop_front();
                        chk("word_data", out_data, w_e.data);
                        chk("word_last", out_last, w_e.last);
                    end
                end
            end else begin
                ar_pend = 1'b0;
            end
        end
    end

    task automatic slave_reset();
        @(posedge clk); #1;
        slv_rst = 1'b1;
        @(posedge clk); #1;
        slv_rst = 1'b0;
    endtask

    task automatic start_cmd(input string name, input logic [AW-1:0] a, input logic [FW-1:0] n);
        @(posedge clk); #1;
        start_fetch      = 1'b1;
        line_addr        = a;
        fetch_word_count = n;
        @(posedge clk); #1;
        start_fetch = 1'b0;
        chk({name, "_fip_high"}, fetch_in_progress, 1);
    endtask

    task automatic wait_idle(input string name, input int budget, output int fall_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fetch_in_progress && n < budget);
        chk({name, "_finished"}, fetch_in_progress, 0);
        fall_cyc = cyc;
        chk({name, "_ar_drained"}, exp_ar.size(), 0);
        chk({name, "_words_drained"}, exp_w.size(), 0);
    endtask

    task automatic wait_words(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (words_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_word_wait"}, (words_seen >= target), 1);
    endtask

    int fall;
    int ar_before;

    initial begin
        nrst = 1'b0; en = 1'b1; start_fetch = 1'b0; fetch_word_count = '0; line_addr = '0;
        out_ready = 1'b1; slv_rst = 1'b1; ar_stall = 0; inj_burst = 0; inj_beat = 0; inj_resp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fip", fetch_in_progress, 0);
        chk("rst_err", error_flag, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("arsize", m_arsize, 3);
        chk("arburst", m_arburst, 1);
        nrst = 1'b1;
        slv_rst = 1'b0;

        // single burst, drop latency of fetch_in_progress after the last beat
        push_ar(32'h1000, 8'd15);
        push_words(32'h1000, 16, 1'b1);
        start_cmd("single", 32'h1000, 16);
        wait_idle("single", 200, fall);
        chk("single_fip_drop_latency", fall - last_cyc, 2);

        // multi-burst
        slave_reset();
        push_ar(32'h2000, 8'd15);
        push_ar(32'h2080, 8'd15);
        push_ar(32'h2100, 8'd7);
        push_words(32'h2000, 40, 1'b1);
        start_cmd("multi", 32'h2000, 40);
        wait_idle("multi", 400, fall);

        // 4 KB page split
        slave_reset();
        push_ar(32'h0FF0, 8'd1);
        push_ar(32'h1000, 8'd5);
        push_words(32'h0FF0, 8, 1'b1);
        start_cmd("page", 32'h0FF0, 8);
        wait_idle("page", 200, fall);

        // output backpressure then global enable freeze
        slave_reset();
        push_ar(32'h4000, 8'd15);
        push_words(32'h4000, 16, 1'b1);
        words_seen = 0;
        start_cmd("bp", 32'h4000, 16);
        wait_words("bp_a", 4, 100);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rready_low", m_rready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_words("bp_b", 8, 100);
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_rready_low", m_rready, 0);
            chk("en_out_valid_low", out_valid, 0);
            chk("en_fip_held", fetch_in_progress, 1);
        end
        @(posedge clk); #1;
        en = 1'b1;
        wait_idle("bp", 300, fall);
        chk("bp_word_count", words_seen, 16);

        // error response on beat 3 of the first burst
        slave_reset();
        inj_burst = 1; inj_beat = 2; inj_resp = 2'b10;
        ar_before = ar_seen;
`ifdef DC_FU_ABORT_ON_ERROR_EN
        push_ar(32'h3000, 8'd15);
        push_words(32'h3000, 16, 1'b0);
`else
        push_ar(32'h3000, 8'd15);
        push_ar(32'h3080, 8'd15);
        push_ar(32'h3100, 8'd7);
        push_words(32'h3000, 40, 1'b1);
`endif
        start_cmd("err", 32'h3000, 40);
        wait_idle("err", 400, fall);
        chk("err_flag", error_flag, 2);
        repeat (3) @(negedge clk);
        chk("err_flag_sticky", error_flag, 2);
`ifdef DC_FU_ABORT_ON_ERROR_EN
        chk("err_ar_count", ar_seen - ar_before, 1);
`else
        chk("err_ar_count", ar_seen - ar_before, 3);
`endif
        inj_burst = 0;

        // zero-length command: one cycle busy, no AR, error cleared
        slave_reset();
        ar_before = ar_seen;
        start_cmd("zero", 32'h8000, 0);
        chk("zero_err_cleared", error_flag, 0);
        @(posedge clk); #1;
        chk("zero_fip_one_cycle", fetch_in_progress, 0);
        repeat (4) @(negedge clk);
        chk("zero_no_ar", ar_seen - ar_before, 0);

        // start_fetch during a stalled ADDR phase is ignored
        slave_reset();
        ar_stall = 3;
        ar_before = ar_seen;
        push_ar(32'h6000, 8'd3);
        push_words(32'h6000, 4, 1'b1);
        start_cmd("ovl", 32'h6000, 4);
        chk("ovl_arvalid", m_arvalid, 1);
        start_fetch = 1'b1; line_addr = 32'h7000; fetch_word_count = 16'd9;
        @(posedge clk); #1;
        start_fetch = 1'b0;
        wait_idle("ovl", 200, fall);
        repeat (5) @(negedge clk);
        chk("ovl_ar_count", ar_seen - ar_before, 1);
        chk("ovl_stays_idle", fetch_in_progress, 0);
        ar_stall = 0;

        // reset in the middle of a data burst
        slave_reset();
        push_ar(32'h5000, 8'd15);
        push_words(32'h5000, 16, 1'b1);
        words_seen = 0;
        start_cmd("mrst", 32'h5000, 16);
        wait_words("mrst", 3, 100);
        @(posedge clk); #1;
        nrst = 1'b0;
        slv_rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_fip", fetch_in_progress, 0);
        chk("mrst_err", error_flag, 0);
        chk("mrst_arvalid", m_arvalid, 0);
        chk("mrst_araddr", m_araddr, 0);
        chk("mrst_arlen", m_arlen, 0);
        chk("mrst_rready", m_rready, 0);
        chk("mrst_out_valid", out_valid, 0);
        nrst = 1'b1;
        slv_rst = 1'b0;
        exp_ar.delete();
        exp_w.delete();

        // recovery after reset, unaligned address is rounded down to the beat
        slave_reset();
        push_ar(32'h9000, 8'd1);
        push_words(32'h9000, 2, 1'b1);
        start_cmd("recover", 32'h9005, 2);
        wait_idle("recover", 100, fall);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: run did not complete within cycle budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
